// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus
// the buffered instruction handshake toward decode.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  Opcode;
  logic [31:0] instr_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect,
    input  redirect_target,
    output instr_valid,
    input  instr_ready,
    output instr,
    output Opcode,
    output instr_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect,
    output redirect_target,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  Opcode,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requester
// feeding a 2-entry instruction buffer toward decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_tag;
  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  logic [31:0] r_buf_instr [DEPTH];
  logic [31:0] r_buf_pc    [DEPTH];

  logic        w_full;
  logic        w_valid;
  logic        w_req;
  logic        w_fire;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_tgt;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  assign w_full  = (r_count == 2'd2);
  assign w_valid = (r_count != 2'd0);
  assign w_tgt   = bus.redirect_target & ~32'h3;

  // No request while reset is held, the buffer is full or a
  // redirect is changing the pc this cycle.
  assign w_req = reset
              && (r_state == S_REQ)
              && !w_full
              && !bus.redirect;

  assign w_fire = w_req && bus.imem_gnt;

  assign w_push = (r_state == S_WAIT)
               && bus.imem_rvalid
               && !bus.redirect;

  assign w_pop = w_valid
              && bus.instr_ready
              && !bus.redirect;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_REQ;
    else        r_state <= w_state_nxt;
  end

  // Next-state: a redirect during WAIT either kills the
  // arriving data or leaves a response still to be dropped.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_REQ: begin
        if (w_fire) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect) begin
          if (bus.imem_rvalid) w_state_nxt = S_REQ;
          else                 w_state_nxt = S_DROP;
        end else if (bus.imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Program counter: redirect wins over sequential advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= w_tgt;
    end else if (w_fire) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Tag remembers the address of the outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag <= 32'h0;
    end else if (w_fire) begin
      r_tag <= r_pc;
    end
  end

  // Buffer occupancy and pointers; a redirect flushes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else if (bus.redirect) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage; contents only visible while counted.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_buf_instr[r_wptr] <= bus.imem_rdata;
      r_buf_pc[r_wptr]    <= r_tag;
    end
  end

  assign w_instr    = w_valid ? r_buf_instr[r_rptr] : 32'h0;
  assign w_instr_pc = w_valid ? r_buf_pc[r_rptr]    : 32'h0;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_instr;
  assign bus.Opcode      = w_instr[6:0];
  assign bus.instr_pc    = w_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios
// then random traffic against a queue-based fetch model.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  int n_err = 0;
  int n_chk = 0;

  // model: outstanding 0=none 1=live 2=dead
  logic [31:0] m_pc;
  logic [31:0] m_tag;
  int          m_out;
  logic [31:0] q_i[$];
  logic [31:0] q_p[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic step(input logic r, input logic rd,
                      input logic [31:0] tgt,
                      input logic rdy, input logic g,
                      input logic rv,
                      input logic [31:0] rdat,
                      output logic fired,
                      output logic [31:0] faddr);
    logic        e_req;
    logic [31:0] e_i;
    logic [31:0] e_p;
    int          old_out;
    @(negedge clk);
    rst_n               = r;
    bus.redirect        = rd;
    bus.redirect_target = tgt;
    bus.instr_ready     = rdy;
    bus.imem_gnt        = g;
    bus.imem_rvalid     = rv;
    bus.imem_rdata      = rdat;
    #1;
    e_req = r && (m_out == 0) && (q_i.size() < 2) && !rd;
    e_i   = (q_i.size() != 0) ? q_i[0] : 32'h0;
    e_p   = (q_p.size() != 0) ? q_p[0] : 32'h0;
    chk("req",    {31'h0, bus.imem_req}, {31'h0, e_req});
    chk("addr",   bus.imem_addr, m_pc);
    chk("valid",  {31'h0, bus.instr_valid},
                  {31'h0, q_i.size() != 0});
    chk("instr",  bus.instr, e_i);
    chk("opcode", {25'h0, bus.Opcode}, {25'h0, e_i[6:0]});
    chk("ipc",    bus.instr_pc, e_p);
    fired = e_req && g;
    faddr = m_pc;
    @(posedge clk);
    old_out = m_out;
    if (!r) begin
      m_pc  = 32'h0;
      m_tag = 32'h0;
      m_out = 0;
      q_i.delete();
      q_p.delete();
    end else if (rd) begin
      q_i.delete();
      q_p.delete();
      m_pc = tgt & ~32'h3;
      if (old_out == 1) m_out = rv ? 0 : 2;
      else if (old_out == 2 && rv) m_out = 0;
    end else begin
      if (q_i.size() != 0 && rdy) begin
        void'(q_i.pop_front());
        void'(q_p.pop_front());
      end
      if (old_out == 1 && rv) begin
        q_i.push_back(rdat);
        q_p.push_back(m_tag);
        m_out = 0;
      end
      if (old_out == 2 && rv) m_out = 0;
      if (e_req && g) begin
        m_tag = m_pc;
        m_pc  = m_pc + 32'd4;
        m_out = 1;
      end
    end
  endtask

  logic        f;
  logic [31:0] fa;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    rst2                 = 1'b0;
    bus2.imem_gnt        = 1'b0;
    bus2.imem_rvalid     = 1'b0;
    bus2.imem_rdata      = 32'h0;
    bus2.redirect        = 1'b0;
    bus2.redirect_target = 32'h0;
    bus2.instr_ready     = 1'b0;
    m_pc  = 32'h0;
    m_tag = 32'h0;
    m_out = 0;

    // reset and first fetch
    step(0, 0, 0, 0, 1, 0, 0, f, fa);
    step(0, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 0, 0, 0, 0, 1, 32'h0050_0113, f, fa);
    #1;
    chk("r32_valid", {31'h0, bus.instr_valid}, 32'h1);
    chk("r32_instr", bus.instr, 32'h0050_0113);
    chk("r32_opc", {25'h0, bus.Opcode}, 32'h13);
    chk("r32_ipc", bus.instr_pc, 32'h0);
    chk("r32_addr", bus.imem_addr, 32'h4);

    // fill the buffer with decode stalled
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 0, 0, 0, 0, 1, mdat(32'h4), f, fa);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 1, 0, 0, f, fa);
    #1;
    chk("r33_req", {31'h0, bus.imem_req}, 32'h0);
    chk("r33_addr", bus.imem_addr, 32'h8);

    // pop, then refill with push and pop together
    step(1, 0, 0, 1, 0, 0, 0, f, fa);
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 0, 0, 1, 0, 1, mdat(32'h8), f, fa);
    #1;
    chk("r35_ipc", bus.instr_pc, 32'h8);

    // redirect while waiting, late data dropped
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 1, 32'h0000_0103, 0, 0, 0, 0, f, fa);
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    #1;
    chk("r34_addr", bus.imem_addr, 32'h100);
    chk("r34_req", {31'h0, bus.imem_req}, 32'h0);
    step(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, f, fa);
    #1;
    chk("r34_empty", {31'h0, bus.instr_valid}, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, f, fa);
    #1;
    chk("r34_req2", {31'h0, bus.imem_req}, 32'h1);

    // reset while waiting, stray response ignored
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(0, 0, 0, 0, 0, 0, 0, f, fa);
    step(1, 0, 0, 0, 0, 1, 32'hBAD0_0BAD, f, fa);
    #1;
    chk("r37_empty", {31'h0, bus.instr_valid}, 32'h0);
    step(1, 0, 0, 0, 1, 0, 0, f, fa);
    step(1, 0, 0, 0, 0, 1, mdat(32'h0), f, fa);
    #1;
    chk("r37_ipc", bus.instr_pc, 32'h0);

    // random traffic
    step(0, 0, 0, 0, 0, 0, 0, f, fa);
    mem_pend = 1'b0;
    mem_cnt  = 0;
    mem_addr = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      logic        r, rd, rdy, g, rv;
      logic [31:0] tgt, rdat;
      r   = ($urandom_range(0, 199) != 0);
      rd  = ($urandom_range(0, 14) == 0);
      tgt = ($urandom_range(0, 1) == 0)
          ? $urandom
          : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      rdy = ($urandom_range(0, 2) != 0);
      g   = !mem_pend && ($urandom_range(0, 3) != 0);
      if (mem_pend) begin
        rv   = (mem_cnt == 0);
        rdat = mdat(mem_addr);
      end else begin
        rv   = ($urandom_range(0, 9) == 0);
        rdat = $urandom;
      end
      step(r, rd, tgt, rdy, g, rv, rdat, f, fa);
      if (mem_pend) begin
        if (rv) mem_pend = 1'b0;
        else    mem_cnt--;
      end
      if (f) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(0, 3);
        mem_addr = fa;
      end
    end

    // wrap at the top of the address space
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("r36_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("r36_req", {31'h0, bus2.imem_req}, 32'h1);
    bus2.imem_gnt = 1'b1;
    @(posedge clk);
    #1;
    chk("r36_wrap", bus2.imem_addr, 32'h0);
    @(negedge clk);
    bus2.imem_gnt    = 1'b0;
    bus2.imem_rvalid = 1'b1;
    bus2.imem_rdata  = 32'h0000_0013;
    @(posedge clk);
    #1;
    chk("r36_ipc", bus2.instr_pc, 32'hFFFF_FFFC);
    chk("r36_valid", {31'h0, bus2.instr_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
